// File: rtl/lu_pkg.sv
// Shared definitions for the logic-unit result collector: op encodings,
// FSM state type and default word width.
package lu_pkg;

    localparam int WORD_W_DEF = 4;
    localparam int CNT_W      = 4;

    localparam logic [2:0] OP_XNOR = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_NAND = 3'd5;
    localparam logic [2:0] OP_NOTA = 3'd6;
    localparam logic [2:0] OP_NOTB = 3'd7;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/lu_select.sv
// Combinational 8:1 pick of one logic-unit result bit by op code.
module lu_select
    import lu_pkg::*;
(
    input  logic [7:0] res,
    input  logic [2:0] op,
    output logic       sel
);

    always_comb begin
        sel = 1'b0;
        case (op)
            OP_XNOR: sel = res[0];
            OP_OR:   sel = res[1];
            OP_XOR:  sel = res[2];
            OP_NOR:  sel = res[3];
            OP_AND:  sel = res[4];
            OP_NAND: sel = res[5];
            OP_NOTA: sel = res[6];
            OP_NOTB: sel = res[7];
            default: sel = 1'b0;
        endcase
    end

endmodule

// File: rtl/lu_collector.sv
// Packs one selected logic-unit result bit per accepted input into WORD_W-bit
// words (first bit in the MSB) and offers each word with parity downstream.
module lu_collector
    import lu_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_res,
    input  logic [2:0]        op,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic              out_par,
    output logic [7:0]        out_words
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(WORD_W);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next, cnt_acc, pad;
    logic [WORD_W-1:0] sr, sr_next, sr_acc;
    logic [WORD_W-1:0] word_r, word_next;
    logic              par_r, par_next;
    logic [7:0]        words_r, words_next;
    logic              sel_bit;

    lu_select u_select (
        .res (in_res),
        .op  (op),
        .sel (sel_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FILL;
            cnt     <= '0;
            sr      <= '0;
            word_r  <= '0;
            par_r   <= 1'b0;
            words_r <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            sr      <= sr_next;
            word_r  <= word_next;
            par_r   <= par_next;
            words_r <= words_next;
        end
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; ready is a pure function of FSM state (FILL accepts,
    // HOLD offers), and the offered word is held unchanged until taken.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        sr_next    = sr;
        word_next  = word_r;
        par_next   = par_r;
        words_next = words_r;
        cnt_acc    = cnt;
        sr_acc     = sr;
        pad        = '0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sr_acc  = {sr[WORD_W-2:0], sel_bit};
                    cnt_acc = cnt + 1'b1;
                end
                sr_next  = sr_acc;
                cnt_next = cnt_acc;
                if (cnt_acc == FULL) begin
                    word_next  = sr_acc;
                    par_next   = ^sr_acc;
                    state_next = HOLD;
                end else if (flush && (cnt_acc != '0)) begin
                    // Left-align the partial word so the first bit stays in the MSB.
                    pad        = FULL - cnt_acc;
                    word_next  = sr_acc << pad;
                    par_next   = ^(sr_acc << pad);
                    state_next = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = FILL;
                    cnt_next   = '0;
                    sr_next    = '0;
                    words_next = words_r + 8'd1;
                end
            end
            default: state_next = FILL;
        endcase
    end

    assign out_word  = word_r;
    assign out_par   = par_r;
    assign out_words = words_r;

endmodule

// File: tb/tb_lu_collector.sv
// Directed bench for lu_collector: inputs change on the falling edge, outputs
// are checked on the falling edge after each rising edge.
module tb_lu_collector;

    localparam int WORD_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_res;
    logic [2:0]        op;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_word;
    logic              out_par;
    logic [7:0]        out_words;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_words;

    always #5 clk = ~clk;

    lu_collector #(.WORD_W(WORD_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_res    (in_res),
        .op        (op),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_par   (out_par),
        .out_words (out_words)
    );

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic idle_inputs();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_res    = 8'h5A;
        op        = 3'd7;
    endtask

    // One accept; in_res/op are scrambled afterwards so late sampling shows up.
    task automatic accept_bit(input logic [7:0] r, input logic [2:0] o, input logic f);
        in_valid = 1'b1;
        in_res   = r;
        op       = o;
        flush    = f;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        in_res   = ~r;
        op       = ~o;
    endtask

    task automatic flush_only();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_words = exp_words + 8'd1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_words = 8'd0;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_word !== 4'b0000) begin n_fail++; $display("FAIL reset_out_word: got %b expected 0000", out_word); end
        n_checks++; if (out_par !== 1'b0) begin n_fail++; $display("FAIL reset_out_par: got %b expected 0", out_par); end
        n_checks++; if (out_words !== 8'd0) begin n_fail++; $display("FAIL reset_out_words: got %0d expected 0", out_words); end
    endtask

    // A6: a=1,b=0 -> xnor0 or1 xor1 nor0 and0 nand1 nota0 notb1
    task automatic test_basic();
        accept_bit(8'hA6, 3'd0, 1'b0);
        accept_bit(8'hA6, 3'd1, 1'b0);
        accept_bit(8'hA6, 3'd2, 1'b0);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %b expected 1", in_ready); end
        accept_bit(8'hA6, 3'd3, 1'b0);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_word !== 4'b0110) begin n_fail++; $display("FAIL basic_word: got %b expected 0110", out_word); end
        n_checks++; if (out_par !== 1'b0) begin n_fail++; $display("FAIL basic_par: got %b expected 0", out_par); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_hold_ready: got %b expected 0", in_ready); end
        drain();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained: got %b expected 0", out_valid); end
        n_checks++; if (out_words !== exp_words) begin n_fail++; $display("FAIL basic_words: got %0d expected %0d", out_words, exp_words); end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 4; i++) accept_bit(8'hA6, 3'd2, 1'b0);
        in_valid = 1'b1;
        in_res   = 8'h00;
        op       = 3'd0;
        flush    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (out_word !== 4'b1111) begin n_fail++; $display("FAIL hold_word[%0d]: got %b expected 1111", i, out_word); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d]: got %b expected 0", i, in_ready); end
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b expected 1", i, out_valid); end
            n_checks++; if (out_par !== 1'b0) begin n_fail++; $display("FAIL hold_par[%0d]: got %b expected 0", i, out_par); end
            n_checks++; if (out_words !== exp_words) begin n_fail++; $display("FAIL hold_words[%0d]: got %0d expected %0d", i, out_words, exp_words); end
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        drain();
        n_checks++; if (out_words !== exp_words) begin n_fail++; $display("FAIL hold_words_after: got %0d expected %0d", out_words, exp_words); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_back_to_fill: got %b expected 1", in_ready); end
    endtask

    task automatic test_flush();
        flush_only();
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got %b expected 0", out_valid); end
        accept_bit(8'hA6, 3'd1, 1'b0);
        accept_bit(8'hA6, 3'd1, 1'b0);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_partial_valid: got %b expected 0", out_valid); end
        flush_only();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_word !== 4'b1100) begin n_fail++; $display("FAIL flush_word: got %b expected 1100", out_word); end
        n_checks++; if (out_par !== 1'b0) begin n_fail++; $display("FAIL flush_par: got %b expected 0", out_par); end
        drain();
        n_checks++; if (out_words !== exp_words) begin n_fail++; $display("FAIL flush_words: got %0d expected %0d", out_words, exp_words); end
    endtask

    task automatic test_flush_accept();
        accept_bit(8'hA6, 3'd1, 1'b0);
        accept_bit(8'hA6, 3'd0, 1'b0);
        accept_bit(8'hA6, 3'd2, 1'b1);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flacc_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_word !== 4'b1010) begin n_fail++; $display("FAIL flacc_word: got %b expected 1010", out_word); end
        n_checks++; if (out_par !== 1'b0) begin n_fail++; $display("FAIL flacc_par: got %b expected 0", out_par); end
        drain();
        accept_bit(8'hA6, 3'd7, 1'b0);
        accept_bit(8'hA6, 3'd6, 1'b0);
        accept_bit(8'hA6, 3'd4, 1'b0);
        accept_bit(8'hA6, 3'd3, 1'b0);
        n_checks++; if (out_word !== 4'b1000) begin n_fail++; $display("FAIL odd_word: got %b expected 1000", out_word); end
        n_checks++; if (out_par !== 1'b1) begin n_fail++; $display("FAIL odd_par: got %b expected 1", out_par); end
        drain();
        n_checks++; if (out_words !== exp_words) begin n_fail++; $display("FAIL flacc_words: got %0d expected %0d", out_words, exp_words); end
    endtask

    task automatic test_reset_hold();
        for (int i = 0; i < 4; i++) accept_bit(8'hA6, 3'd5, 1'b0);
        rst       = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b0;
        exp_words = 8'd0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rsthold_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_words !== 8'd0) begin n_fail++; $display("FAIL rsthold_words: got %0d expected 0", out_words); end
        n_checks++; if (out_word !== 4'b0000) begin n_fail++; $display("FAIL rsthold_word: got %b expected 0000", out_word); end
    endtask

    task automatic test_reset_mid();
        accept_bit(8'hA6, 3'd1, 1'b0);
        accept_bit(8'hA6, 3'd1, 1'b0);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_res    = 8'hA6;
        op        = 3'd1;
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_words !== 8'd0) begin n_fail++; $display("FAIL rstmid_words: got %0d expected 0", out_words); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
        accept_bit(8'hA6, 3'd0, 1'b0);
        accept_bit(8'hA6, 3'd0, 1'b0);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale_count: got %b expected 0", out_valid); end
        accept_bit(8'hA6, 3'd0, 1'b0);
        accept_bit(8'hA6, 3'd1, 1'b0);
        n_checks++; if (out_word !== 4'b0001) begin n_fail++; $display("FAIL rstmid_word: got %b expected 0001", out_word); end
        n_checks++; if (out_par !== 1'b1) begin n_fail++; $display("FAIL rstmid_par: got %b expected 1", out_par); end
        drain();
        n_checks++; if (out_words !== exp_words) begin n_fail++; $display("FAIL rstmid_words_after: got %0d expected %0d", out_words, exp_words); end
    endtask

    // Fills words from pseudo-random vectors until the delivered count wraps.
    task automatic test_wrap();
        logic [7:0]        r;
        logic [2:0]        o;
        logic [WORD_W-1:0] exp_word;
        int                start;
        start = int'(exp_words);
        for (int w = start; w < 256; w++) begin
            exp_word = '0;
            for (int b = 0; b < WORD_W; b++) begin
                r = 8'($urandom_range(0, 255));
                o = 3'($urandom_range(0, 7));
                exp_word = {exp_word[WORD_W-2:0], r[o]};
                accept_bit(r, o, 1'b0);
            end
            n_checks++; if (out_word !== exp_word) begin n_fail++; $display("FAIL wrap_word[%0d]: got %b expected %b", w, out_word, exp_word); end
            n_checks++; if (out_par !== ^exp_word) begin n_fail++; $display("FAIL wrap_par[%0d]: got %b expected %b", w, out_par, ^exp_word); end
            drain();
            n_checks++; if (out_words !== exp_words) begin n_fail++; $display("FAIL wrap_words[%0d]: got %0d expected %0d", w, out_words, exp_words); end
        end
        n_checks++; if (out_words !== 8'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d expected 0", out_words); end
    endtask

    initial begin
        exp_words = 8'd0;
        test_reset();
        test_basic();
        test_hold();
        test_flush();
        test_flush_accept();
        test_reset_hold();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
